// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port: word array with a programmable
// number of wait states per access, saturating access statistics and a sticky error flag.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_w,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] mem_data_r,
    output logic        mem_wait,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] stall_count,
    output logic        err
);
    localparam int unsigned LP_AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LP_SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  LP_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;
    logic [15:0] r_stall_count;
    logic        r_err;

    logic             w_req;
    logic [31:0]      w_off;
    logic             w_in_range;
    logic [LP_AW-1:0] w_idx;
    logic             w_accept;
    logic             w_wait;
    logic             w_bad;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_req      = mem_read | mem_write;
    // Offset compare also rejects addresses below BASE_ADDR, which wrap to huge values.
    assign w_off      = mem_addr - BASE_ADDR;
    assign w_in_range = ({1'b0, w_off} < LP_SPAN);
    assign w_idx      = w_off[LP_AW+1:2];
    assign w_bad      = !w_in_range || (mem_read && mem_write);

    assign mem_data_r = (mem_read && w_in_range) ? r_mem[w_idx] : 32'd0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wait      = 1'b0;
        w_accept    = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (WAIT_CYCLES == 0) begin
                            w_accept = 1'b1;
                        end else begin
                            w_wait      = 1'b1;
                            w_state_nxt = S_BUSY;
                            w_cnt_nxt   = LP_CNT_INIT;
                        end
                    end
                end
                S_BUSY: begin
                    if (!w_req) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        w_wait    = 1'b1;
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_rd_count    <= 16'd0;
            r_wr_count    <= 16'd0;
            r_stall_count <= 16'd0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_wait) r_stall_count <= sat_inc(r_stall_count);
            if (w_accept && mem_write) r_wr_count <= sat_inc(r_wr_count);
            if (w_accept && mem_read && !mem_write) r_rd_count <= sat_inc(r_rd_count);
            if (w_accept && w_bad) r_err <= 1'b1;
        end
    end

    // Array contents survive reset; w_accept is already forced low while rst_n is low.
    always_ff @(posedge clk) begin
        if (w_accept && mem_write && w_in_range) r_mem[w_idx] <= mem_data_w;
    end

    assign mem_wait    = w_wait;
    assign rd_count    = r_rd_count;
    assign wr_count    = r_wr_count;
    assign stall_count = r_stall_count;
    assign err         = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES 2, 0 and 3
// exercising stall timing, back-to-back traffic, flush, out-of-range, dual request and reset.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n [3];
    logic [31:0] a     [3];
    logic [31:0] dw    [3];
    logic        rd    [3];
    logic        wr    [3];
    logic [31:0] dr    [3];
    logic        wt    [3];
    logic [15:0] rc    [3];
    logic [15:0] wc    [3];
    logic [15:0] sc    [3];
    logic        er    [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(1024),
            .BASE_ADDR  (32'h0000_0000),
            .WAIT_CYCLES((g == 0) ? 2 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .mem_addr   (a[g]),
            .mem_data_w (dw[g]),
            .mem_read   (rd[g]),
            .mem_write  (wr[g]),
            .mem_data_r (dr[g]),
            .mem_wait   (wt[g]),
            .rd_count   (rc[g]),
            .wr_count   (wc[g]),
            .stall_count(sc[g]),
            .err        (er[g])
        );
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the accept edge with the request dropped.
    task automatic do_acc(input int d, input logic r, input logic w, input logic [31:0] ad,
                          input logic [31:0] wd, output logic [31:0] rdat, output int nw);
        bit done;
        done = 0;
        nw   = 0;
        rdat = 32'd0;
        rd[d] = r; wr[d] = w; a[d] = ad; dw[d] = wd;
        for (int k = 0; k < 40 && !done; k++) begin
            #4;
            if (wt[d]) nw++;
            else begin
                rdat = dr[d];
                done = 1;
            end
            @(posedge clk); #1;
        end
        rd[d] = 1'b0; wr[d] = 1'b0;
        if (!done) check_val("access_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] rdat;
    int          nw;
    int          tot;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; a[i] = 0; dw[i] = 0; rd[i] = 0; wr[i] = 0;
        end
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        #4;
        check_val("rst_wait", 32'(wt[0]), 32'd0);
        check_val("rst_rd_count", 32'(rc[0]), 32'd0);
        check_val("rst_wr_count", 32'(wc[0]), 32'd0);
        check_val("rst_stall_count", 32'(sc[0]), 32'd0);
        check_val("rst_err", 32'(er[0]), 32'd0);
        @(posedge clk); #1;

        // WAIT_CYCLES=2: store then load
        do_acc(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rdat, nw);
        check_val("w2_sw_waits", nw, 32'd2);
        do_acc(0, 1'b1, 1'b0, 32'h10, 32'd0, rdat, nw);
        check_val("w2_lw_waits", nw, 32'd2);
        check_val("w2_lw_data", rdat, 32'hDEADBEEF);
        check_val("w2_wr_count", 32'(wc[0]), 32'd1);
        check_val("w2_rd_count", 32'(rc[0]), 32'd1);
        check_val("w2_stall_count", 32'(sc[0]), 32'd4);
        check_val("w2_err", 32'(er[0]), 32'd0);

        // WAIT_CYCLES=0: back-to-back stores and loads
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            do_acc(1, 1'b0, 1'b1, 32'(i * 4), 32'(i * 3), rdat, nw);
            tot += nw;
        end
        for (int i = 0; i < 8; i++) begin
            do_acc(1, 1'b1, 1'b0, 32'(i * 4), 32'd0, rdat, nw);
            tot += nw;
            check_val($sformatf("w0_lw_data_%0d", i), rdat, 32'(i * 3));
        end
        check_val("w0_total_waits", tot, 32'd0);
        check_val("w0_wr_count", 32'(wc[1]), 32'd8);
        check_val("w0_rd_count", 32'(rc[1]), 32'd8);
        check_val("w0_stall_count", 32'(sc[1]), 32'd0);

        // WAIT_CYCLES=3: flush of a store
        do_acc(2, 1'b0, 1'b1, 32'h20, 32'h0000_00A5, rdat, nw);
        check_val("w3_sw_waits", nw, 32'd3);
        wr[2] = 1'b1; a[2] = 32'h20; dw[2] = 32'h55;
        #4;
        check_val("flush_wait_c0", 32'(wt[2]), 32'd1);
        @(posedge clk); #1;
        wr[2] = 1'b0;
        #4;
        check_val("flush_wait_drop", 32'(wt[2]), 32'd0);
        @(posedge clk); #1;
        check_val("flush_wr_count", 32'(wc[2]), 32'd1);
        do_acc(2, 1'b1, 1'b0, 32'h20, 32'd0, rdat, nw);
        check_val("flush_lw_waits", nw, 32'd3);
        check_val("flush_lw_data", rdat, 32'h0000_00A5);

        // Both requests high
        do_acc(2, 1'b0, 1'b1, 32'h8, 32'h0000_0BAD, rdat, nw);
        check_val("both_pre_err", 32'(er[2]), 32'd0);
        do_acc(2, 1'b1, 1'b1, 32'h8, 32'h0000_1234, rdat, nw);
        check_val("both_old_data", rdat, 32'h0000_0BAD);
        check_val("both_err", 32'(er[2]), 32'd1);
        check_val("both_rd_count", 32'(rc[2]), 32'd1);
        check_val("both_wr_count", 32'(wc[2]), 32'd3);
        do_acc(2, 1'b1, 1'b0, 32'h8, 32'd0, rdat, nw);
        check_val("both_new_data", rdat, 32'h0000_1234);

        // Out-of-range load
        do_acc(0, 1'b1, 1'b0, 32'h1000, 32'd0, rdat, nw);
        check_val("oor_waits", nw, 32'd2);
        check_val("oor_data", rdat, 32'd0);
        check_val("oor_err", 32'(er[0]), 32'd1);
        check_val("oor_rd_count", 32'(rc[0]), 32'd2);
        do_acc(0, 1'b1, 1'b0, 32'h10, 32'd0, rdat, nw);
        check_val("oor_then_valid_data", rdat, 32'hDEADBEEF);
        check_val("oor_err_sticky", 32'(er[0]), 32'd1);

        // Reset in the middle of a stalled store
        do_acc(0, 1'b0, 1'b1, 32'h4, 32'h0000_0011, rdat, nw);
        wr[0] = 1'b1; a[0] = 32'h4; dw[0] = 32'h77;
        #4;
        check_val("rst_busy_wait", 32'(wt[0]), 32'd1);
        @(posedge clk); #1;
        rst_n[0] = 1'b0;
        #4;
        check_val("rst_low_wait", 32'(wt[0]), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr[0] = 1'b0;
        rst_n[0] = 1'b1;
        #4;
        check_val("post_rst_wait", 32'(wt[0]), 32'd0);
        check_val("post_rst_data", dr[0], 32'd0);
        check_val("post_rst_rd_count", 32'(rc[0]), 32'd0);
        check_val("post_rst_wr_count", 32'(wc[0]), 32'd0);
        check_val("post_rst_stall_count", 32'(sc[0]), 32'd0);
        check_val("post_rst_err", 32'(er[0]), 32'd0);
        @(posedge clk); #1;
        do_acc(0, 1'b1, 1'b0, 32'h4, 32'd0, rdat, nw);
        check_val("rst_word4_kept", rdat, 32'h0000_0011);
        check_val("rst_lw_waits", nw, 32'd2);
        do_acc(0, 1'b1, 1'b0, 32'h10, 32'd0, rdat, nw);
        check_val("rst_word10_kept", rdat, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
